// File: rtl/nios_system_keys_in.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_keys_in
// Brief    : Avalon-MM key input PIO. Synchronises (and optionally debounces
//            with KEYS_DEBOUNCE_EN) key lines and latches rising edges.
// Revision : 1.0  initial release
// ============================================================================
module nios_system_keys_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             w_wr_en;

    assign w_wr_en = chipselect && !write_n;

`ifdef KEYS_DEBOUNCE_EN
    localparam int               c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] cnt_q [WIDTH];
    logic [c_CNT_W-1:0] cnt_d [WIDTH];

    // A bit is accepted only after differing from stable for DEBOUNCE_CYCLES edges.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == c_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    localparam int c_unused_debounce = DEBOUNCE_CYCLES;

    assign stable_d = s2_q;
`endif

    assign w_clr = (w_wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // New rising edges are OR-ed in after the clear so a same-cycle set wins.
    always_comb begin
        edge_d    = (edge_q & ~w_clr) | (stable_d & ~stable_q);
        irqmask_d = irqmask_q;
        if (w_wr_en && (address == 2'd2)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(stable_q);
            2'd2:    readdata_d = 32'(irqmask_q);
            2'd3:    readdata_d = 32'(edge_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stable_q   <= '0;
            irqmask_q  <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            stable_q   <= stable_d;
            irqmask_q  <= irqmask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
        end
    end

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = |writedata[31:WIDTH];
        end
    endgenerate

    assign readdata = readdata_q;
    assign irq      = |(edge_q & irqmask_q);

endmodule
`default_nettype wire
